fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It holds the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Returned instructions are buffered in a 2-entry queue and presented as a {pc, pc_plus4, instr} bundle with a valid flag. The IF/ID register captures the bundle whenever its write enable (!stall_i) is high. Branch and jump redirects from EX flush all in-flight and buffered instructions.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   FETCH_XLEN    - PC width carried in the IF/ID bundle
//   NOP_INSTR     - addi x0,x0,0, shown on the bundle after reset
//   fetch_state_t - request tracker states
//   if_id_t       - {pc, pc_plus4, instr} bundle handed to the IF/ID register
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned ILEN       = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_plus4;
        logic [ILEN-1:0]       instr;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/gnt/rvalid bus.
//   req    - fetch request (fetch -> memory)
//   addr   - word-aligned fetch address (fetch -> memory)
//   gnt    - request accepted this cycle (memory -> fetch)
//   rvalid - response data valid (memory -> fetch)
//   rdata  - returned instruction (memory -> fetch)
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of IF/ID bundles with a registered head.
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - enqueue a bundle
//   pop        - dequeue the head (ignored when empty)
//   flush      - drop all entries; head payload keeps its last value
//   head       - current head bundle (registered)
//   head_valid - queue non-empty
//   occupancy  - number of entries (0..2)
module fetch_queue
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  if_id_t     din,
    output if_id_t     head,
    output logic       head_valid,
    output logic [1:0] occupancy
);

    if_id_t     head_q;
    if_id_t     tail_q;
    logic [1:0] count_q;
    logic       push_eff;
    logic       pop_eff;

    assign push_eff   = push && (count_q != 2'd2);
    assign pop_eff    = pop && (count_q != 2'd0);
    assign head       = head_q;
    assign head_valid = (count_q != 2'd0);
    assign occupancy  = count_q;

    // Shift-register FIFO: entry 0 always sits in head_q so the outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '{pc: '0, pc_plus4: FETCH_XLEN'(4), instr: NOP_INSTR};
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) head_q <= din;
                    else                 tail_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    // Draining the last entry leaves head_q as-is so the payload stays stable.
                    if (count_q == 2'd2) head_q <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Requests are only issued with a free slot, so a push into a full queue is an upstream bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && (count_q == 2'd2)));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch feeding the IF/ID register.
//   clk, rst        - clock, synchronous active-high reset
//   stall_i         - IF/ID hold; bundle consumed when if_valid_o && !stall_i
//   redirect_i      - flush and restart fetch at redirect_pc_i
//   redirect_pc_i   - redirect target (low two bits ignored)
//   imem            - instruction-memory bus, single outstanding request
//   if_valid_o      - bundle valid
//   if_pc_o         - PC of the bundled instruction
//   if_pc_plus4_o   - if_pc_o + 4
//   if_instr_o      - bundled instruction
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    fetch_stage_if.master      imem,
    output logic               if_valid_o,
    output logic [XLEN-1:0]    if_pc_o,
    output logic [XLEN-1:0]    if_pc_plus4_o,
    output logic [31:0]        if_instr_o
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DROP = DROP;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            push;
    logic            pop;
    logic            req_c;
    logic [1:0]      occupancy;
    if_id_t          push_data;
    if_id_t          head;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Request only when idle and a response is guaranteed a slot.
    assign req_c     = (state_q == ST_IDLE) && (occupancy <= 2'd1) && !redirect_i && !rst;
    assign imem.req  = req_c;
    assign imem.addr = pc_q;

    assign pop = if_valid_o && !stall_i;

    assign push_data = '{pc:       FETCH_XLEN'(req_pc_q),
                         pc_plus4: FETCH_XLEN'(req_pc_q + XLEN'(4)),
                         instr:    imem.rdata};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next state: redirect outranks grant and response; an outstanding response is dropped.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            if (state_q == ST_WAIT) state_d = imem.rvalid ? ST_IDLE : ST_DROP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_c && imem.gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem.rvalid) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_i),
        .din        (push_data),
        .head       (head),
        .head_valid (if_valid_o),
        .occupancy  (occupancy)
    );

    assign if_pc_o       = XLEN'(head.pc);
    assign if_pc_plus4_o = XLEN'(head.pc_plus4);
    assign if_instr_o    = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed bundles.
// The memory model answers each grant one cycle later with {8'hA5, addr[23:0]}.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        auto_rsp;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_stage_if #(.XLEN(32)) imem_bus ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem_bus),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_pc_plus4_o (if_pc4),
        .if_instr_o    (if_instr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic [31:0] instr);
        check_val({tag, "_valid"}, 32'(if_valid), 32'(v));
        check_val({tag, "_pc"},    if_pc,    pc);
        check_val({tag, "_pc4"},   if_pc4,   pc4);
        check_val({tag, "_instr"}, if_instr, instr);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_val({tag, "_req"}, 32'(imem_bus.req), 32'(req));
        if (req) check_val({tag, "_addr"}, imem_bus.addr, addr);
    endtask

    // One clock; the memory model answers a grant taken at this edge during the next cycle.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = imem_bus.req && imem_bus.gnt;
        a    = imem_bus.addr;
        @(posedge clk);
        #1;
        imem_bus.rvalid = auto_rsp && fire;
        imem_bus.rdata  = {8'hA5, a[23:0]};
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_bus.gnt = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        auto_rsp = 1'b1;
        tick();
        tick();
        check_req("rst_hold", 1'b0, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1: back-to-back fetch from RESET_PC
        do_reset();
        check_out("s1_reset", 1'b0, 32'h0, 32'h4, 32'h0000_0013);
        check_req("s1_c0", 1'b1, 32'h100);
        tick();
        check_req("s1_c1", 1'b0, 32'h0);
        tick();
        check_out("s1_b0", 1'b1, 32'h100, 32'h104, 32'hA500_0100);
        check_req("s1_c2", 1'b1, 32'h104);
        tick();
        check_val("s1_c3_valid", 32'(if_valid), 32'd0);
        tick();
        check_out("s1_b1", 1'b1, 32'h104, 32'h108, 32'hA500_0104);
        check_req("s1_c4", 1'b1, 32'h108);

        // 2: stall six cycles from the first bundle, queue fills to two
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        #1;
        check_out("s2_first", 1'b1, 32'h100, 32'h104, 32'hA500_0100);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check_out("s2_frozen", 1'b1, 32'h100, 32'h104, 32'hA500_0100);
            check_req("s2_full", 1'b0, 32'h0);
            tick();
        end
        stall = 1'b0;
        #1;
        check_out("s2_rel0", 1'b1, 32'h100, 32'h104, 32'hA500_0100);
        tick();
        check_out("s2_rel1", 1'b1, 32'h104, 32'h108, 32'hA500_0104);
        check_req("s2_resume", 1'b1, 32'h108);
        tick();
        check_val("s2_gap_valid", 32'(if_valid), 32'd0);
        tick();
        check_out("s2_b2", 1'b1, 32'h108, 32'h10C, 32'hA500_0108);
        check_req("s2_next", 1'b1, 32'h10C);

        // 3: grant withheld three cycles on 0x104
        do_reset();
        tick();
        tick();
        imem_bus.gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_req("s3_nogrant", 1'b1, 32'h104);
            tick();
        end
        imem_bus.gnt = 1'b1;
        #1;
        check_req("s3_grant", 1'b1, 32'h104);
        tick();
        tick();
        check_out("s3_b1", 1'b1, 32'h104, 32'h108, 32'hA500_0104);
        check_req("s3_next", 1'b1, 32'h108);

        // 4: redirect while waiting; the late response is dropped
        do_reset();
        tick();
        tick();
        auto_rsp = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        check_req("s4_redir", 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_req("s4_drop", 1'b0, 32'h0);
        check_val("s4_drop_valid", 32'(if_valid), 32'd0);
        tick();
        imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
        #1;
        check_req("s4_late", 1'b0, 32'h0);
        tick();
        check_val("s4_after_valid", 32'(if_valid), 32'd0);
        check_val("s4_after_instr", if_instr, 32'hA500_0100);
        check_req("s4_restart", 1'b1, 32'h200);
        auto_rsp = 1'b1;
        tick();
        tick();
        check_out("s4_b200", 1'b1, 32'h200, 32'h204, 32'hA500_0200);

        // 5a: redirect coincident with rvalid, unaligned target
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        #1;
        check_out("s5_coinc", 1'b0, 32'h0, 32'h4, 32'h0000_0013);
        check_req("s5_align", 1'b1, 32'h200);
        // 5b: redirect with two entries queued under stall
        tick();
        stall = 1'b1;
        tick();
        tick();
        tick();
        check_out("s5_full", 1'b1, 32'h200, 32'h204, 32'hA500_0200);
        check_req("s5_full", 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        check_out("s5_flush", 1'b0, 32'h200, 32'h204, 32'hA500_0200);
        check_req("s5_restart", 1'b1, 32'h300);

        // 6: PC wrap, then reset while a response is outstanding
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_req("s6_redir", 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_req("s6_top", 1'b1, 32'hFFFF_FFFC);
        tick();
        tick();
        check_out("s6_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hA5FF_FFFC);
        check_req("s6_wrap", 1'b1, 32'h0);
        auto_rsp = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_req("s6_in_rst", 1'b0, 32'h0);
        check_out("s6_rst", 1'b0, 32'h0, 32'h4, 32'h0000_0013);
        rst = 1'b0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
        #1;
        check_req("s6_post_rst", 1'b1, 32'h100);
        auto_rsp = 1'b1;
        tick();
        check_out("s6_ignored", 1'b0, 32'h0, 32'h4, 32'h0000_0013);
        check_req("s6_first", 1'b1, 32'h100);
        imem_bus.gnt = 1'b1;
        tick();
        tick();
        check_out("s6_b100", 1'b1, 32'h100, 32'h104, 32'hA500_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
